// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared op/write-back encodings and MEM-stage state for mem_access_stage
package mem_access_stage_pkg;
  typedef enum logic [2:0] {ST_NONE, ST_SB, ST_SH, ST_SW} st_op_e;
  typedef enum logic [2:0] {LD_NONE, LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW} ld_op_e;
  typedef enum logic [1:0] {WB_ALU, WB_LOAD, WB_PC4, WB_EXT} wsel_e;
  typedef enum logic {IDLE, BUSY} state_e;
endpackage

// File: rtl/mem_access_stage_load_format.sv
// mem_load_format: selects the addressed lane of a read word and sign/zero-extends it
module mem_load_format
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b    = rdata[8*addr_lo +: 8];
    h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data = op == LD_LB  ? {{24{b[7]}}, b} :
           op == LD_LBU ? {24'b0, b} :
           op == LD_LH  ? {{16{h[15]}}, h} :
           op == LD_LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage with req/ack data-memory bus; MEM_MISALIGN_TRAP_EN enables misalign_err trap
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  MEM_ram_wdata_op,
  input  logic [2:0]  MEM_ram_rdata_op,
  input  logic        MEM_rf_we,
  input  logic [1:0]  MEM_rf_wsel,
  input  logic [4:0]  MEM_wR,
  input  logic [31:0] MEM_pc4,
  input  logic [31:0] MEM_alu_c,
  input  logic [31:0] MEM_rD2,
  input  logic [31:0] MEM_ext,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        fwd_we,
  output logic [4:0]  fwd_wR,
  output logic [31:0] fwd_wd,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalign_err,
`endif
  output logic        WB_rf_we,
  output logic [4:0]  WB_wR,
  output logic [31:0] WB_wd
);
  state_e      state_q, state_d;
  logic        req_q, req_d, we_q, we_d, wb_we_q, wb_we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wb_wd_q, wb_wd_d;
  logic [3:0]  be_q, be_d;
  logic [4:0]  wb_wr_q, wb_wr_d;
  logic        is_st, is_ld, memop, misalign, go;
  logic [31:0] ld_data, nonld_val, sel_val;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        err_q, err_d;
`endif

  mem_load_format u_fmt (
    .op      (MEM_ram_rdata_op),
    .addr_lo (MEM_alu_c[1:0]),
    .rdata   (dmem_rdata),
    .data    (ld_data)
  );

  always_comb begin
    is_st     = MEM_ram_wdata_op != ST_NONE;
    is_ld     = MEM_ram_rdata_op != LD_NONE;
    memop     = is_st | is_ld;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign  = is_st ? ((MEM_ram_wdata_op == ST_SH) & MEM_alu_c[0]) |
                        ((MEM_ram_wdata_op == ST_SW) & (|MEM_alu_c[1:0]))
                      : ((MEM_ram_rdata_op == LD_LH | MEM_ram_rdata_op == LD_LHU) & MEM_alu_c[0]) |
                        ((MEM_ram_rdata_op == LD_LW) & (|MEM_alu_c[1:0]));
    err_d     = 1'b0;
`else
    misalign  = 1'b0;
`endif
    go        = (state_q == IDLE) & memop & ~misalign;
    nonld_val = MEM_rf_wsel == WB_PC4 ? MEM_pc4 : MEM_rf_wsel == WB_EXT ? MEM_ext : MEM_alu_c;
    sel_val   = MEM_rf_wsel == WB_LOAD ? ld_data : nonld_val;
    mem_stall = state_q == IDLE ? go : ~dmem_ack;
    fwd_we    = (state_q == IDLE) & MEM_rf_we & (MEM_rf_wsel != WB_LOAD);
    fwd_wR    = MEM_wR;
    fwd_wd    = nonld_val;
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    wb_we_d   = 1'b0;
    wb_wr_d   = wb_wr_q;
    wb_wd_d   = wb_wd_q;
    if (go) begin
      state_d = BUSY;
      req_d   = 1'b1;
      we_d    = is_st;
      addr_d  = {MEM_alu_c[31:2], 2'b00};
      be_d    = MEM_ram_wdata_op == ST_SB ? 4'b0001 << MEM_alu_c[1:0] :
                MEM_ram_wdata_op == ST_SH ? (MEM_alu_c[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata_d = MEM_ram_wdata_op == ST_SB ? {4{MEM_rD2[7:0]}} :
                MEM_ram_wdata_op == ST_SH ? {2{MEM_rD2[15:0]}} : MEM_rD2;
    end else if ((state_q == IDLE & ~memop) | (state_q == BUSY & dmem_ack)) begin
      state_d = IDLE;
      req_d   = 1'b0;
      wb_we_d = MEM_rf_we;
      wb_wr_d = MEM_wR;
      wb_wd_d = sel_val;
    end
`ifdef MEM_MISALIGN_TRAP_EN
    else if (state_q == IDLE) err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wb_we_q <= 1'b0;
      wb_wr_q <= '0;
      wb_wd_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      wb_we_q <= wb_we_d;
      wb_wr_q <= wb_wr_d;
      wb_wd_q <= wb_wd_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign misalign_err = err_q;
`endif

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign WB_rf_we   = wb_we_q;
  assign WB_wR      = wb_wr_q;
  assign WB_wd      = wb_wd_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized self-checking bench for mem_access_stage against a behavioural model
module tb_mem_access_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic [2:0]  wop = '0, rop = '0;
  logic        rf_we = 1'b0, ack = 1'b0;
  logic [1:0]  wsel = '0;
  logic [4:0]  wr = '0;
  logic [31:0] pc4 = '0, alu_c = '0, rd2 = '0, ext = '0, rdata = '0;
  logic        dmem_req, dmem_we, mem_stall, fwd_we, WB_rf_we;
  logic [31:0] dmem_addr, dmem_wdata, fwd_wd, WB_wd;
  logic [3:0]  dmem_be;
  logic [4:0]  fwd_wR, WB_wR;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif
  int total = 0, bad = 0;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .MEM_ram_wdata_op(wop), .MEM_ram_rdata_op(rop), .MEM_rf_we(rf_we), .MEM_rf_wsel(wsel),
    .MEM_wR(wr), .MEM_pc4(pc4), .MEM_alu_c(alu_c), .MEM_rD2(rd2), .MEM_ext(ext),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(rdata), .dmem_ack(ack), .mem_stall(mem_stall),
    .fwd_we(fwd_we), .fwd_wR(fwd_wR), .fwd_wd(fwd_wd),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
`endif
    .WB_rf_we(WB_rf_we), .WB_wR(WB_wR), .WB_wd(WB_wd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_val(logic [1:0] ws);
    return ws == 2 ? pc4 : ws == 3 ? ext : alu_c;
  endfunction

  function automatic logic [31:0] exp_load(int op, logic [31:0] a, logic [31:0] rd);
    longint v;
    if (op == 1 || op == 2) begin
      v = (rd >> (8 * (a % 4))) & 255;
      if (op == 1 && v > 127) v -= 256;
    end else if (op == 3 || op == 4) begin
      v = (rd >> (16 * ((a / 2) % 2))) & 65535;
      if (op == 3 && v > 32767) v -= 65536;
    end else v = rd;
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_be(int op, logic [31:0] a);
    if (op == 1) return 4'(1 << (a % 4));
    if (op == 2) return ((a / 2) % 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] exp_wdata(int op, logic [31:0] d);
    if (op == 1) return (d & 255) * 32'h01010101;
    if (op == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dmem_req !== 0 || dmem_we !== 0 || dmem_addr !== 0 || dmem_be !== 0 || dmem_wdata !== 0)
      begin bad++; $display("FAIL reset_bus req=%b we=%b addr=%h be=%b wdata=%h exp all 0", dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata); end
    total++;
    if (WB_rf_we !== 0 || WB_wR !== 0 || WB_wd !== 0 || mem_stall !== 0)
      begin bad++; $display("FAIL reset_wb we=%b wR=%0d wd=%h stall=%b exp 0", WB_rf_we, WB_wR, WB_wd, mem_stall); end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    for (int i = 0; i < 20; i++) begin
      wop = 0; rop = 0;
      if (i == 0) begin alu_c = 32'h1234; wsel = 0; wr = 5; rf_we = 1; end
      else begin
        alu_c = $urandom; pc4 = $urandom; ext = $urandom; wr = 5'($urandom);
        rf_we = 1'($urandom); wsel = $urandom_range(0, 2) == 0 ? 2'd0 : 2'($urandom_range(2, 3));
      end
      ack = 1'($urandom);
      #1;
      total++;
      if (mem_stall !== 0 || fwd_we !== rf_we || fwd_wR !== wr || fwd_wd !== exp_val(wsel))
        begin bad++; $display("FAIL alu_fwd i=%0d stall=%b we=%b wR=%0d wd=%h exp 0 %b %0d %h", i, mem_stall, fwd_we, fwd_wR, fwd_wd, rf_we, wr, exp_val(wsel)); end
      @(posedge clk); #1;
      total++;
      if (WB_rf_we !== rf_we || WB_wR !== wr || WB_wd !== exp_val(wsel) || dmem_req !== 0)
        begin bad++; $display("FAIL alu_wb i=%0d we=%b wR=%0d wd=%h req=%b exp %b %0d %h 0", i, WB_rf_we, WB_wR, WB_wd, dmem_req, rf_we, wr, exp_val(wsel)); end
    end
    ack = 0;
  endtask

  task automatic test_store();
    logic [31:0] a, d;
    int op, waits, stalls;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin op = 1; a = 32'h103; d = 32'hAB; waits = 3; end
      else begin
        op = $urandom_range(1, 3); a = $urandom; d = $urandom; waits = $urandom_range(0, 3);
`ifdef MEM_MISALIGN_TRAP_EN
        if (op == 2) a[0] = 1'b0;
        if (op == 3) a[1:0] = 2'b00;
`endif
      end
      wop = 3'(op); rop = 0; rf_we = 0; wsel = 0; wr = 5'($urandom); alu_c = a; rd2 = d; ack = 0;
      stalls = 0;
      #1; if (mem_stall) stalls++;
      @(posedge clk); #1;
      total++;
      if (dmem_req !== 1 || dmem_we !== 1 || dmem_addr !== {a[31:2], 2'b00} || WB_rf_we !== 0)
        begin bad++; $display("FAIL store_issue i=%0d req=%b we=%b addr=%h wbwe=%b exp 1 1 %h 0", i, dmem_req, dmem_we, dmem_addr, WB_rf_we, {a[31:2], 2'b00}); end
      total++;
      if (dmem_be !== exp_be(op, a) || dmem_wdata !== exp_wdata(op, d))
        begin bad++; $display("FAIL store_lanes i=%0d be=%b wdata=%h exp %b %h", i, dmem_be, dmem_wdata, exp_be(op, a), exp_wdata(op, d)); end
      for (int k = 0; k < waits; k++) begin
        #1; if (mem_stall) stalls++;
        @(posedge clk); #1;
        total++;
        if (dmem_req !== 1 || dmem_be !== exp_be(op, a) || dmem_wdata !== exp_wdata(op, d) || WB_rf_we !== 0)
          begin bad++; $display("FAIL store_hold i=%0d req=%b be=%b wdata=%h wbwe=%b", i, dmem_req, dmem_be, dmem_wdata, WB_rf_we); end
      end
      ack = 1;
      #1; if (mem_stall) stalls++;
      @(posedge clk); #1;
      ack = 0; wop = 0;
      total++;
      if (dmem_req !== 0 || WB_rf_we !== 0 || stalls != waits + 1)
        begin bad++; $display("FAIL store_done i=%0d req=%b wbwe=%b stalls=%0d exp 0 0 %0d", i, dmem_req, WB_rf_we, stalls, waits + 1); end
    end
  endtask

  task automatic test_load();
    logic [31:0] a, rd, ex;
    int op, waits, stalls;
    for (int i = 0; i < 16; i++) begin
      waits = 0; rf_we = 1; wsel = 1; wr = 5'($urandom);
      case (i)
        0: begin op = 1; a = 2; rd = 32'h0080_0000; end
        1: begin op = 2; a = 2; rd = 32'h0080_0000; end
        2: begin op = 3; a = 2; rd = 32'h8001_0000; end
        3: begin op = 5; a = 0; rd = 32'h8001_0000; end
        default: begin
          op = $urandom_range(1, 5); a = $urandom; rd = $urandom; waits = $urandom_range(0, 3);
          rf_we = 1'($urandom); wsel = $urandom_range(0, 1) ? 2'd1 : 2'($urandom);
          alu_c = a; pc4 = $urandom; ext = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
          if (op == 3 || op == 4) a[0] = 1'b0;
          if (op == 5) a[1:0] = 2'b00;
`endif
        end
      endcase
      wop = 0; rop = 3'(op); alu_c = a; ack = 0; rdata = $urandom;
      ex = wsel == 1 ? exp_load(op, a, rd) : exp_val(wsel);
      stalls = 0;
      #1; if (mem_stall) stalls++;
      total++;
      if (fwd_we !== (rf_we && wsel != 1))
        begin bad++; $display("FAIL load_fwd i=%0d fwd_we=%b exp %b", i, fwd_we, rf_we && wsel != 1); end
      @(posedge clk); #1;
      total++;
      if (dmem_req !== 1 || dmem_we !== 0 || dmem_addr !== {a[31:2], 2'b00} || WB_rf_we !== 0 || fwd_we !== 0)
        begin bad++; $display("FAIL load_issue i=%0d req=%b we=%b addr=%h wbwe=%b fwd=%b", i, dmem_req, dmem_we, dmem_addr, WB_rf_we, fwd_we); end
      for (int k = 0; k < waits; k++) begin
        #1; if (mem_stall) stalls++;
        @(posedge clk); #1;
        rdata = $urandom;
      end
      rdata = rd; ack = 1;
      #1; if (mem_stall) stalls++;
      @(posedge clk); #1;
      ack = 0; rop = 0;
      total++;
      if (dmem_req !== 0 || WB_rf_we !== rf_we || WB_wR !== wr || WB_wd !== ex || stalls != waits + 1)
        begin bad++; $display("FAIL load_done i=%0d op=%0d a=%h req=%b we=%b wR=%0d wd=%h stalls=%0d exp 0 %b %0d %h %0d", i, op, a, dmem_req, WB_rf_we, WB_wR, WB_wd, stalls, rf_we, wr, ex, waits + 1); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ex;
    for (int i = 0; i < 8; i++) begin
      wr = 5'($urandom); rf_we = 1; alu_c = $urandom; pc4 = $urandom; ext = $urandom;
      if (i % 2 == 0) begin
        rop = 3'd5; wsel = 1; alu_c[1:0] = 2'b00; rdata = $urandom; ex = rdata;
        @(posedge clk); #1;
        ack = 1;
      end else begin
        rop = 0; wsel = 2'($urandom_range(2, 3)); ex = exp_val(wsel);
      end
      #1;
      total++;
      if (mem_stall !== 0)
        begin bad++; $display("FAIL b2b_stall i=%0d stall=%b exp 0", i, mem_stall); end
      @(posedge clk); #1;
      ack = 0;
      total++;
      if (WB_rf_we !== 1 || WB_wR !== wr || WB_wd !== ex || dmem_req !== 0)
        begin bad++; $display("FAIL b2b_wb i=%0d we=%b wR=%0d wd=%h req=%b exp 1 %0d %h 0", i, WB_rf_we, WB_wR, WB_wd, dmem_req, wr, ex); end
    end
    rop = 0;
  endtask

  task automatic test_reset_mid();
    wop = 0; rop = 3'd5; alu_c = 0; rf_we = 1; wsel = 1; rdata = $urandom;
    @(posedge clk); #1;
    ack = 1; rst = 1;
    @(posedge clk); #1;
    total++;
    if (dmem_req !== 0 || WB_rf_we !== 0)
      begin bad++; $display("FAIL rst_ack req=%b wbwe=%b exp 0 0", dmem_req, WB_rf_we); end
    rst = 0; ack = 0; rop = 0; wsel = 0; wr = 7; alu_c = $urandom;
    #1;
    total++;
    if (mem_stall !== 0)
      begin bad++; $display("FAIL rst_idle stall=%b exp 0", mem_stall); end
    @(posedge clk); #1;
    total++;
    if (WB_rf_we !== 1 || WB_wd !== alu_c)
      begin bad++; $display("FAIL rst_resume we=%b wd=%h exp 1 %h", WB_rf_we, WB_wd, alu_c); end
    wop = 3'd3; rf_we = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; wop = 0;
    total++;
    if (dmem_req !== 0)
      begin bad++; $display("FAIL rst_noack req=%b exp 0", dmem_req); end
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    wop = 0; rop = 3'd5; alu_c = 32'h5; rf_we = 1; wsel = 1;
    #1;
    total++;
    if (mem_stall !== 0)
      begin bad++; $display("FAIL mis_stall stall=%b exp 0", mem_stall); end
    @(posedge clk); #1;
    total++;
    if (dmem_req !== 0 || misalign_err !== 1 || WB_rf_we !== 0)
      begin bad++; $display("FAIL mis_trap req=%b err=%b wbwe=%b exp 0 1 0", dmem_req, misalign_err, WB_rf_we); end
    rop = 0; rf_we = 0;
    @(posedge clk); #1;
    total++;
    if (misalign_err !== 0)
      begin bad++; $display("FAIL mis_pulse err=%b exp 0", misalign_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM stage of the five-stage pipeline: consumes the EX/MEM pipeline register outputs, performs loads and stores against the data-memory bus with a req/ack handshake, aligns store data and sign- or zero-extends load data, selects the write-back value, and registers the result into the MEM/WB boundary. It stalls the upstream pipeline while a memory access is outstanding and inserts a bubble into write-back during the stall.

## Interface
- No parameters; data width fixed at 32, register index width at 5.
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- MEM_ram_wdata_op  in  3  store op: 0 none, 1 SB, 2 SH, 3 SW
- MEM_ram_rdata_op  in  3  load op: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW
- MEM_rf_we  in  1  register-file write enable
- MEM_rf_wsel  in  2  write-back source: 0 alu_c, 1 load data, 2 pc4, 3 ext
- MEM_wR  in  5  destination register
- MEM_pc4, MEM_alu_c, MEM_rD2, MEM_ext  in  32 each  PC+4, address/ALU result, store data, immediate
- dmem_req  out  1  access request, registered
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address (low 2 bits zero)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned store data
- dmem_rdata  in  32  read word, valid with dmem_ack
- dmem_ack  in  1  access complete
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- fwd_we, fwd_wR[4:0], fwd_wd[31:0]  out  forwarding of current non-load result, combinational
- WB_rf_we  out  1; WB_wR  out  5; WB_wd  out  32  registered MEM/WB outputs

## Operation
- States IDLE, BUSY. memop = wdata_op≠0 or rdata_op≠0.
- IDLE, no memop: at edge WB_* ← (rf_we, wR, selected value); stall 0.
- IDLE, memop: mem_stall=1; at edge latch addr/be/wdata/we, dmem_req←1, go BUSY; WB_rf_we←0 (bubble).
- BUSY: req and bus fields held stable. mem_stall = ~dmem_ack. On edge with ack: req←0, IDLE, WB_* ← result (load data formatted per rdata_op and alu_c[1:0]); else WB_rf_we←0.
- Store alignment: SB replicates byte to all lanes, be = 1<<addr[1:0]; SH replicates halfword, be = 0011 or 1100 by addr[1]; SW be=1111.
- Load: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend; load with wsel≠1 still completes access.
- Both op fields nonzero is illegal; store takes priority.
- fwd_we = rf_we & (wsel≠1) in IDLE; 0 otherwise (loads resolved by hazard unit stall).
- wR=0 writes pass through; register file ignores x0.

## Timing
- Reset: state IDLE, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_be 0, dmem_wdata 0, WB_rf_we 0, WB_wR 0, WB_wd 0; mem_stall follows combinationally.
- Non-memory latency 1 cycle, no stall. Memory op: minimum 1 stall cycle (ack in first BUSY cycle), +1 per extra ack wait.
- ack ignored in IDLE. ack and rst same edge: rst wins, result discarded.
- Reset mid-access: req drops next edge; memory must tolerate abandoned request.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]≠0 issues no request, no stall, WB_rf_we←0, output misalign_err (1 bit, registered, one-cycle pulse, reset 0).
- Undefined: no misalign_err port; offending low address bits ignored (halfword uses addr[1], word uses lane 0).

## Structure
- Shared package: store/load op encodings, wsel encodings, state enum.
- One sub-module natural: mem_load_format (combinational lane select + extension).

## Test plan
- ADD result alu_c=0x1234, wsel 0, wR=5 -> next edge WB_wd=0x1234, WB_rf_we=1, stall never high.
- SB addr 0x103, rD2=0xAB -> dmem_addr 0x100, be 1000, wdata 0xABABABAB; ack after 3 BUSY cycles -> stall high 4 cycles.
- LB addr 0x2, rdata 0x0080_0000, ack first BUSY cycle -> WB_wd 0xFFFFFF80; LBU -> 0x00000080.
- LH addr 0x2, rdata 0x8001_0000 -> WB_wd 0xFFFF8001; LW -> 0x80010000.
- rst asserted in BUSY with ack same cycle -> req 0, WB_rf_we 0, state IDLE next cycle.
- With MEM_MISALIGN_TRAP_EN, LW addr 0x5 -> no dmem_req, misalign_err pulse 1 cycle, WB_rf_we 0.
